platform_collider: RTL and testbench
====================================

Name: platform_collider

Overview:
- Consumes the platform position array and activation mask from the platform generator. Once per frame it scans all platform slots against the doodle's feet box and reports whether the doodle lands, and on which platform.
- Sits between the platform generator and the doodle physics block. Physics uses the landing pulse to snap the doodle's y position and restart the jump.
- Scans sequentially, one slot per clock, so only one comparator set is needed instead of 93.

Parameters:
- N_PLAT, 93, number of platform slots scanned.
- PLAT_W, 100, platform sprite width in pixels.
- DOODLE_W, 80, doodle hitbox width in pixels.
- DOODLE_H, 80, doodle hitbox height in pixels; the feet are at doodle_y + DOODLE_H.
- LAND_TOL, 16, vertical landing band depth below a platform's top edge, in pixels.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse at the start of vertical blank
- doodle_x  in  11 signed  doodle hitbox left edge
- doodle_y  in  11 signed  doodle hitbox top edge
- doodle_vy  in  8 signed  vertical velocity; positive means falling
- platforms  in  [N_PLAT-1:0][1:0][10:0] signed  per slot: [0] = top y, [1] = left x
- platform_activation  in  N_PLAT  per slot: 1 = platform present
- busy  out  1  high while a scan is in progress
- done  out  1  one-cycle pulse when the result is valid
- landed  out  1  one-cycle pulse, coincident with done, when a landing was found
- landed_index  out  7  slot index of the landing platform
- landed_y  out  11 signed  corrected doodle_y, equal to platform top y − DOODLE_H

Behaviour:
- Reset values: busy=0, done=0, landed=0, landed_index=0, landed_y=0, state=IDLE, scan index=0.
- State IDLE:
  - On frame_start, latch doodle_x, doodle_y, doodle_vy, clear the hit flag, set idx=0, go to SCAN.
  - busy=0 in this state.
- State SCAN:
  - busy=1; one slot is evaluated per cycle, combinationally from the live platforms[idx] value.
  - Slot idx is a hit when all of the following are true:
    - platform_activation[idx]=1;
    - latched vy > 0;
    - latched doodle_x + DOODLE_W − 1 ≥ px;
    - latched doodle_x ≤ px + PLAT_W − 1;
    - py ≤ latched doodle_y + DOODLE_H ≤ py + LAND_TOL − 1.
  - All arithmetic is sign-extended to 13 bits before add and compare, so negative or off-screen platforms cannot overflow.
  - Priority: the first hit (lowest index) is kept; later hits are ignored. On the first hit, capture idx into landed_index and py − DOODLE_H into landed_y (truncated to 11 bits).
  - When idx = N_PLAT−1, go to REPORT; otherwise idx increments.
- State REPORT:
  - Lasts one cycle: done=1, landed=hit flag, busy=0. Then go to IDLE.
- landed_index and landed_y hold their values until the next captured hit or reset. Both are valid only while landed=1.
- Latency: frame_start at cycle T → slots 0..92 evaluated at cycles T+1..T+93 → done at T+94.
- frame_start received in SCAN or REPORT is ignored; a scan is never restarted.
- frame_start in IDLE during the same cycle REPORT exits cannot occur; REPORT→IDLE happens first, and the next pulse is accepted from IDLE.
- Reset mid-scan: return to IDLE on the next edge. No done or landed pulse is produced, and all outputs take their reset values.
- A doodle with vy ≤ 0 (rising or stationary) never lands. The scan still runs to completion and done still pulses.
- Platforms changing during a scan: each slot uses the value present in its own evaluation cycle. No snapshot of the array is taken.

Test Plan:
- Basic landing:
  - Stimulus: slot 5 at (y=400, x=300), active; doodle x=320, y=325, vy=+3; pulse frame_start.
  - Required: done and landed high at T+94, landed_index=5, landed_y=320, busy high for cycles T+1..T+93.
- Rising doodle:
  - Stimulus: same geometry with vy=−4.
  - Required: done=1, landed=0 at T+94; landed_index and landed_y unchanged from the previous test.
- Horizontal edges:
  - doodle_x=221 with px=300 → hit (221+79=300).
  - doodle_x=220 → no hit.
  - doodle_x=399 → hit.
  - doodle_x=400 → no hit.
- Vertical band and activation:
  - Feet at py+15 → hit; feet at py+16 → no hit; feet at py−1 → no hit.
  - Inactive slot with otherwise perfect geometry → no hit.
- Priority and negative coordinates:
  - Stimulus: slots 10 and 40 both hit; slot 0 at y=−162 overlapping a doodle with y=−240.
  - Required: landed_index=0 with slot 0 active; landed_index=10 with slot 0 inactive.
- Control:
  - Extra frame_start at T+50 → ignored, single done at T+94.
  - rst at T+30 → busy=0 at T+31, no done pulse.
  - A fresh frame_start after reset produces done exactly 94 cycles later.

Source files
------------

// File: rtl/platform_collider.sv
// ============================================================================
// Module   : platform_collider
// Purpose  : Per-frame sequential scan of platform slots against the doodle's
//            feet box; reports the first (lowest-index) landing platform.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module platform_collider #(
    parameter int N_PLAT   = 93,
    parameter int PLAT_W   = 100,
    parameter int DOODLE_W = 80,
    parameter int DOODLE_H = 80,
    parameter int LAND_TOL = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                frame_start,
    input  logic signed [10:0]                  doodle_x,
    input  logic signed [10:0]                  doodle_y,
    input  logic signed [7:0]                   doodle_vy,
    input  logic signed [N_PLAT-1:0][1:0][10:0] platforms,
    input  logic        [N_PLAT-1:0]            platform_activation,
    output logic                                busy,
    output logic                                done,
    output logic                                landed,
    output logic        [6:0]                   landed_index,
    output logic signed [10:0]                  landed_y
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCAN   = 2'd1,
        S_REPORT = 2'd2
    } state_t;

    localparam logic        [6:0]  c_last_idx = 7'(N_PLAT - 1);
    localparam logic signed [12:0] c_one      = 13'sd1;
    localparam logic signed [12:0] c_plat_w   = 13'(PLAT_W);
    localparam logic signed [12:0] c_doodle_w = 13'(DOODLE_W);
    localparam logic signed [12:0] c_doodle_h = 13'(DOODLE_H);
    localparam logic signed [12:0] c_tol      = 13'(LAND_TOL);
    localparam logic signed [10:0] c_snap_h   = 11'(DOODLE_H);

    state_t                r_state;
    state_t                w_state_next;
    logic        [6:0]     r_idx;
    logic signed [10:0]    r_dx;
    logic signed [10:0]    r_dy;
    logic signed [7:0]     r_vy;
    logic                  r_hit;

    logic signed [10:0]    w_py_raw;
    logic signed [10:0]    w_px_raw;
    logic signed [12:0]    w_py;
    logic signed [12:0]    w_px;
    logic signed [12:0]    w_dx;
    logic signed [12:0]    w_feet;
    logic                  w_hit;

    // Slot geometry is read live each cycle; no snapshot of the array is kept.
    assign w_py_raw = platforms[r_idx][0];
    assign w_px_raw = platforms[r_idx][1];
    assign w_py     = {{2{w_py_raw[10]}}, w_py_raw};
    assign w_px     = {{2{w_px_raw[10]}}, w_px_raw};
    assign w_dx     = {{2{r_dx[10]}}, r_dx};
    assign w_feet   = {{2{r_dy[10]}}, r_dy} + c_doodle_h;

    assign w_hit = platform_activation[r_idx]
                && (r_vy > 8'sd0)
                && ((w_dx + c_doodle_w - c_one) >= w_px)
                && (w_dx <= (w_px + c_plat_w - c_one))
                && (w_feet >= w_py)
                && (w_feet <= (w_py + c_tol - c_one));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_idx        <= 7'd0;
            r_dx         <= 11'sd0;
            r_dy         <= 11'sd0;
            r_vy         <= 8'sd0;
            r_hit        <= 1'b0;
            landed_index <= 7'd0;
            landed_y     <= 11'sd0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (frame_start) begin
                        r_dx  <= doodle_x;
                        r_dy  <= doodle_y;
                        r_vy  <= doodle_vy;
                        r_hit <= 1'b0;
                        r_idx <= 7'd0;
                    end
                end
                S_SCAN: begin
                    // Lowest index wins: only the first hit of the scan is captured.
                    if (w_hit && !r_hit) begin
                        r_hit        <= 1'b1;
                        landed_index <= r_idx;
                        landed_y     <= w_py_raw - c_snap_h;
                    end
                    if (r_idx != c_last_idx) begin
                        r_idx <= r_idx + 7'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        landed       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (frame_start) begin
                    w_state_next = S_SCAN;
                end
            end
            S_SCAN: begin
                busy = 1'b1;
                if (r_idx == c_last_idx) begin
                    w_state_next = S_REPORT;
                end
            end
            S_REPORT: begin
                done         = 1'b1;
                landed       = r_hit;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_platform_collider.sv
// ============================================================================
// Module   : tb_platform_collider
// Purpose  : Directed, table-driven checks of platform_collider landing logic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_platform_collider;

    localparam int N = 93;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      frame_start = 1'b0;
    logic signed [10:0]        doodle_x = '0;
    logic signed [10:0]        doodle_y = '0;
    logic signed [7:0]         doodle_vy = '0;
    logic signed [N-1:0][1:0][10:0] plat = '0;
    logic        [N-1:0]       act = '0;
    logic                      busy;
    logic                      done;
    logic                      landed;
    logic        [6:0]         landed_index;
    logic signed [10:0]        landed_y;

    int tests  = 0;
    int failed = 0;

    platform_collider dut (
        .clk                 (clk),
        .rst                 (rst),
        .frame_start         (frame_start),
        .doodle_x            (doodle_x),
        .doodle_y            (doodle_y),
        .doodle_vy           (doodle_vy),
        .platforms           (plat),
        .platform_activation (act),
        .busy                (busy),
        .done                (done),
        .landed              (landed),
        .landed_index        (landed_index),
        .landed_y            (landed_y)
    );

    always #5 clk = ~clk;

    typedef struct {
        int slot; int py; int px; bit act_on;
        int dx; int dy; int vy;
        bit exp_land; int exp_idx; int exp_y;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            failed++;
            $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Pulses frame_start and watches 120 cycles; cnt counts edges starting
    // with the one that samples frame_start.
    task automatic run_frame(input int fs_at, input int rst_at,
                             output int done_cnt, output int first_done,
                             output int land_at_done, output int ctrl_ok);
        bit exp_busy;
        done_cnt = 0; first_done = 0; land_at_done = 0; ctrl_ok = 1;
        @(negedge clk);
        frame_start = 1'b1;
        for (int cnt = 1; cnt <= 120; cnt++) begin
            @(posedge clk);
            #1;
            frame_start = (cnt == fs_at);
            rst         = (cnt == rst_at);
            exp_busy = (cnt <= 93) && ((rst_at == 0) || (cnt <= rst_at));
            if (busy !== exp_busy) ctrl_ok = 0;
            if (landed && !done) ctrl_ok = 0;
            if (done === 1'b1) begin
                if (done_cnt == 0) begin
                    first_done   = cnt;
                    land_at_done = int'(landed);
                end
                done_cnt++;
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        int dc, fd, ld, ok;
        int exp_li, exp_ly;
        string tag;

        vecs[0]  = '{5,  400, 300, 1, 320, 325,  3, 1, 5,  320};
        vecs[1]  = '{5,  400, 300, 1, 320, 325, -4, 0, 0,  0};
        vecs[2]  = '{7,  400, 300, 1, 221, 325,  3, 1, 7,  320};
        vecs[3]  = '{7,  400, 300, 1, 220, 325,  3, 0, 0,  0};
        vecs[4]  = '{12, 400, 300, 1, 399, 325,  3, 1, 12, 320};
        vecs[5]  = '{12, 400, 300, 1, 400, 325,  3, 0, 0,  0};
        vecs[6]  = '{20, 200, 50,  1, 50,  135,  3, 1, 20, 120};
        vecs[7]  = '{20, 200, 50,  1, 50,  136,  3, 0, 0,  0};
        vecs[8]  = '{20, 200, 50,  1, 50,  119,  3, 0, 0,  0};
        vecs[9]  = '{33, 400, 300, 0, 320, 325,  3, 0, 0,  0};
        vecs[10] = '{33, 400, 300, 1, 320, 325,  0, 0, 0,  0};
        vecs[11] = '{92, 400, 300, 1, 320, 325,  3, 1, 92, 320};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("reset_busy",   int'(busy), 0);
        check("reset_done",   int'(done), 0);
        check("reset_landed", int'(landed), 0);
        check("reset_index",  int'(landed_index), 0);
        check("reset_y",      int'(landed_y), 0);

        exp_li = 0; exp_ly = 0;
        for (int i = 0; i < 12; i++) begin
            plat = '0; act = '0;
            plat[vecs[i].slot][0] = 11'(vecs[i].py);
            plat[vecs[i].slot][1] = 11'(vecs[i].px);
            act[vecs[i].slot]     = vecs[i].act_on;
            doodle_x  = 11'(vecs[i].dx);
            doodle_y  = 11'(vecs[i].dy);
            doodle_vy = 8'(vecs[i].vy);
            run_frame(0, 0, dc, fd, ld, ok);
            if (vecs[i].exp_land) begin
                exp_li = vecs[i].exp_idx;
                exp_ly = vecs[i].exp_y;
            end
            tag = $sformatf("v%0d", i);
            check({tag, "_latency"}, fd, 94);
            check({tag, "_ndone"},   dc, 1);
            check({tag, "_busy"},    ok, 1);
            check({tag, "_landed"},  ld, int'(vecs[i].exp_land));
            check({tag, "_index"},   int'(landed_index), exp_li);
            check({tag, "_y"},       int'(landed_y), exp_ly);
        end

        // Priority among three overlapping slots, all at negative y.
        plat = '0; act = '0;
        plat[0][0]  = -11'sd162; plat[0][1]  = 11'sd300;
        plat[10][0] = -11'sd170; plat[10][1] = 11'sd300;
        plat[40][0] = -11'sd165; plat[40][1] = 11'sd300;
        act[0] = 1'b1; act[10] = 1'b1; act[40] = 1'b1;
        doodle_x = 11'sd320; doodle_y = -11'sd240; doodle_vy = 8'sd5;
        run_frame(0, 0, dc, fd, ld, ok);
        check("prio0_landed", ld, 1);
        check("prio0_index",  int'(landed_index), 0);
        check("prio0_y",      int'(landed_y), -242);

        act[0] = 1'b0;
        run_frame(0, 0, dc, fd, ld, ok);
        check("prio10_landed", ld, 1);
        check("prio10_index",  int'(landed_index), 10);
        check("prio10_y",      int'(landed_y), -250);

        // Extra frame_start mid-scan must be ignored.
        run_frame(50, 0, dc, fd, ld, ok);
        check("extra_fs_ndone",   dc, 1);
        check("extra_fs_latency", fd, 94);
        check("extra_fs_busy",    ok, 1);

        // Reset mid-scan: busy drops, no done, outputs cleared.
        run_frame(0, 30, dc, fd, ld, ok);
        check("rst_ndone",  dc, 0);
        check("rst_busy",   ok, 1);
        check("rst_index",  int'(landed_index), 0);
        check("rst_y",      int'(landed_y), 0);

        run_frame(0, 0, dc, fd, ld, ok);
        check("post_rst_latency", fd, 94);
        check("post_rst_ndone",   dc, 1);
        check("post_rst_landed",  ld, 1);
        check("post_rst_index",   int'(landed_index), 10);
        check("post_rst_y",       int'(landed_y), -250);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
